// File: rtl/legv8_multicycle_control.sv
// Multi-cycle control sequencer for the LEGv8 core.
// Steps each instruction through fetch/decode/execute/memory/writeback,
// sharing one ALU and one unified memory port. A timeout while waiting on
// mem_ready_i, or an illegal opcode, parks the FSM in ERROR until reset.
// Optional build macro: LEGV8_PERF_CNT_EN adds cycle and instruction counters.
//
//   state   | meaning
//   FETCH   | read instruction at PC, PC <= PC+4 on mem_ready
//   DECODE  | read registers, pick execution path from opcode
//   EXEC_R  | ALU performs R-type operation
//   R_WB    | write ALUOut to register file
//   ADDR    | compute load/store effective address
//   MEM_RD  | read data memory at ALUOut
//   LD_WB   | write MDR to register file
//   MEM_WR  | write register Rt to data memory
//   CBZ     | test Rt for zero, branch if so
//   B       | unconditional branch
//   ERROR   | illegal opcode or memory timeout, absorbing

module legv8_multicycle_control #(
    parameter int MEM_WAIT_MAX = 15
`ifdef LEGV8_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [10:0] opcode_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        i_or_d_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        pc_source_o,
    output logic        reg2loc_o,
    output logic        reg_write_o,
    output logic        mem_to_reg_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic [3:0]  state_o,
    output logic        err_o
`ifdef LEGV8_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instr_cnt_o
`endif
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_R_WB   = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_LD_WB  = 4'd6,
        S_MEM_WR = 4'd7,
        S_CBZ    = 4'd8,
        S_B      = 4'd9,
        S_ERROR  = 4'd15
    } state_e;

    localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       err_q;
    logic       waiting;
    logic       timeout;

    assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // one more idle cycle would push the wait count past the limit
    assign timeout = (wait_q >= WAIT_MAX);

    // state, wait counter and sticky error registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_q | (state_d == S_ERROR);
        end
    end

    // next-state and wait-counter update
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready_i)  state_d = S_DECODE;
                else if (timeout) state_d = S_ERROR;
            end
            S_DECODE: begin
                casez (opcode_i)
                    11'b10001011000,
                    11'b11001011000,
                    11'b10001010000,
                    11'b10101010000: state_d = S_EXEC_R;
                    11'b11111000010,
                    11'b11111000000: state_d = S_ADDR;
                    11'b10110100???: state_d = S_CBZ;
                    11'b000101?????: state_d = S_B;
                    default:         state_d = S_ERROR;
                endcase
            end
            S_EXEC_R: state_d = S_R_WB;
            S_R_WB:   state_d = S_FETCH;
            // only LDUR and STUR reach ADDR; bit 1 tells them apart
            S_ADDR:   state_d = opcode_i[1] ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready_i)  state_d = S_LD_WB;
                else if (timeout) state_d = S_ERROR;
            end
            S_LD_WB:  state_d = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready_i)  state_d = S_FETCH;
                else if (timeout) state_d = S_ERROR;
            end
            S_CBZ:    state_d = S_FETCH;
            S_B:      state_d = S_FETCH;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_ERROR;
        endcase
        if (waiting && !mem_ready_i && (state_d == state_q))
            wait_d = wait_q + 8'd1;
    end

    // datapath strobes decoded from the current state
    always_comb begin
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        i_or_d_o     = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_source_o  = 1'b0;
        reg2loc_o    = 1'b0;
        reg_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE: reg2loc_o = (opcode_i == 11'b11111000000) || (opcode_i[10:3] == 8'b10110100);
            S_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b10;
            end
            S_R_WB:   reg_write_o = 1'b1;
            S_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
            end
            S_MEM_RD: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
            end
            S_LD_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
                reg2loc_o   = 1'b1;
            end
            S_CBZ: begin
                alu_src_a_o = 1'b1;
                reg2loc_o   = 1'b1;
                alu_op_o    = 2'b01;
                pc_write_o  = zero_i;
                pc_source_o = zero_i;
            end
            S_B: begin
                pc_write_o  = 1'b1;
                pc_source_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o = state_q;
    assign err_o   = err_q;

`ifdef LEGV8_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;
    logic             instr_done;

    assign instr_done = (state_q == S_R_WB) || (state_q == S_LD_WB) || (state_q == S_CBZ) ||
                        (state_q == S_B) || ((state_q == S_MEM_WR) && mem_ready_i);

    // free-running performance counters, wrapping naturally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_ERROR) cycle_cnt_q <= cycle_cnt_q + 1'b1;
            if (instr_done)         instr_cnt_q <= instr_cnt_q + 1'b1;
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
    assign instr_cnt_o = instr_cnt_q;
`endif

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Self-checking bench for legv8_multicycle_control: directed scenarios plus a
// randomized instruction stream checked against a per-instruction trace model.
module tb_legv8_multicycle_control;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [10:0] opcode_i = '0;
    logic        zero_i = 1'b0;
    logic        mem_ready_i = 1'b0;
    logic        mem_read_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o, pc_source_o;
    logic        reg2loc_o, reg_write_o, mem_to_reg_o, alu_src_a_o;
    logic [1:0]  alu_src_b_o, alu_op_o;
    logic [3:0]  state_o;
    logic        err_o;
`ifdef LEGV8_PERF_CNT_EN
    logic [3:0]  cycle_cnt_o, instr_cnt_o;
    logic [3:0]  obs_cyc, obs_ins;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ILL  = 11'b11111111111;

    localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4;

    legv8_multicycle_control #(
        .MEM_WAIT_MAX(15)
`ifdef LEGV8_PERF_CNT_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .i_or_d_o(i_or_d_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
        .pc_source_o(pc_source_o), .reg2loc_o(reg2loc_o), .reg_write_o(reg_write_o),
        .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .alu_op_o(alu_op_o), .state_o(state_o), .err_o(err_o)
`ifdef LEGV8_PERF_CNT_EN
        , .cycle_cnt_o(cycle_cnt_o), .instr_cnt_o(instr_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Strobe vector order: mem_read, mem_write, i_or_d, ir_write, pc_write,
    // pc_source, reg2loc, reg_write, mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[1:0]
    function automatic logic [13:0] ref_strobes(input int st, input logic [10:0] op,
                                                input logic z, input logic rdy);
        logic mr, mw, iod, irw, pcw, pcs, r2l, rw, mtr, sa;
        logic [1:0] sb, ao;
        logic [7:0] top8;
        top8 = op[10:3];
        {mr, mw, iod, irw, pcw, pcs, r2l, rw, mtr, sa} = '0;
        sb = 2'b00;
        ao = 2'b00;
        case (st)
            0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            1:  r2l = (op == OP_STUR) || (top8 == 8'b10110100);
            2:  begin sa = 1; ao = 2'b10; end
            3:  rw = 1;
            4:  begin sa = 1; sb = 2'b10; end
            5:  begin mr = 1; iod = 1; end
            6:  begin rw = 1; mtr = 1; end
            7:  begin mw = 1; iod = 1; r2l = 1; end
            8:  begin sa = 1; r2l = 1; ao = 2'b01; pcw = z; pcs = z; end
            9:  begin pcw = 1; pcs = 1; end
            default: ;
        endcase
        return {mr, mw, iod, irw, pcw, pcs, r2l, rw, mtr, sa, sb, ao};
    endfunction

    function automatic logic [10:0] rand_op(input int kind);
        logic [10:0] op;
        case (kind)
            K_R: case ($urandom_range(0, 3))
                     0: op = 11'b10001011000;
                     1: op = 11'b11001011000;
                     2: op = 11'b10001010000;
                     default: op = 11'b10101010000;
                 endcase
            K_LD:  op = OP_LDUR;
            K_ST:  op = OP_STUR;
            K_CBZ: op = {8'b10110100, 3'($urandom_range(0, 7))};
            default: op = {6'b000101, 5'($urandom_range(0, 31))};
        endcase
        return op;
    endfunction

    // Apply inputs for one cycle, sample outputs on the falling edge.
    task automatic drive_cycle(input logic r, input logic [10:0] op, input logic z,
                               input logic rdy, output logic [3:0] st,
                               output logic [13:0] sb, output logic e);
        rst_i = r; opcode_i = op; zero_i = z; mem_ready_i = rdy;
        @(negedge clk_i);
        st = state_o;
        e  = err_o;
        sb = {mem_read_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o, pc_source_o,
              reg2loc_o, reg_write_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o};
`ifdef LEGV8_PERF_CNT_EN
        obs_cyc = cycle_cnt_o;
        obs_ins = instr_cnt_o;
`endif
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        logic [3:0] st; logic [13:0] sb; logic e;
        drive_cycle(1'b1, '0, 1'b0, 1'b0, st, sb, e);
        drive_cycle(1'b1, '0, 1'b0, 1'b0, st, sb, e);
    endtask

    // Run one instruction: fw idle fetch cycles, mw idle memory cycles.
    // The expected state trace is built from the instruction's phase list.
    task automatic run_instr(input int kind, input logic [10:0] op, input int fw,
                             input int mw, input logic z, input string nm);
        int   sts[$];
        logic rdys[$];
        logic [3:0] st; logic [13:0] sb, ex; logic e;
        for (int i = 0; i < fw; i++) begin sts.push_back(0); rdys.push_back(1'b0); end
        sts.push_back(0); rdys.push_back(1'b1);
        sts.push_back(1); rdys.push_back(1'($urandom_range(0, 1)));
        case (kind)
            K_R: begin
                sts.push_back(2); rdys.push_back(1'($urandom_range(0, 1)));
                sts.push_back(3); rdys.push_back(1'($urandom_range(0, 1)));
            end
            K_LD: begin
                sts.push_back(4); rdys.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < mw; i++) begin sts.push_back(5); rdys.push_back(1'b0); end
                sts.push_back(5); rdys.push_back(1'b1);
                sts.push_back(6); rdys.push_back(1'($urandom_range(0, 1)));
            end
            K_ST: begin
                sts.push_back(4); rdys.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < mw; i++) begin sts.push_back(7); rdys.push_back(1'b0); end
                sts.push_back(7); rdys.push_back(1'b1);
            end
            K_CBZ: begin sts.push_back(8); rdys.push_back(1'($urandom_range(0, 1))); end
            default: begin sts.push_back(9); rdys.push_back(1'($urandom_range(0, 1))); end
        endcase
        for (int i = 0; i < sts.size(); i++) begin
            drive_cycle(1'b0, op, z, rdys[i], st, sb, e);
            ex = ref_strobes(sts[i], op, z, rdys[i]);
            n_cmp++;
            if (st !== 4'(sts[i])) begin
                n_bad++;
                $display("FAIL %s state[%0d]: got %0d expected %0d", nm, i, st, sts[i]);
            end
            n_cmp++;
            if (sb !== ex) begin
                n_bad++;
                $display("FAIL %s strobes[%0d]: got %b expected %b", nm, i, sb, ex);
            end
            n_cmp++;
            if (e !== 1'b0) begin
                n_bad++;
                $display("FAIL %s err[%0d]: got %b expected 0", nm, i, e);
            end
            n_cmp++;
            if ((sb[13] & sb[12]) !== 1'b0 || (sb[9] & sb[6]) !== 1'b0) begin
                n_bad++;
                $display("FAIL %s exclusive strobes[%0d]: got %b expected no mr&mw or pcw&rw", nm, i, sb);
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] st; logic [13:0] sb; logic e;
        do_reset();
        drive_cycle(1'b0, OP_ADD, 1'b0, 1'b0, st, sb, e);
        n_cmp++;
        if (st !== 4'd0 || e !== 1'b0 || sb !== 14'b10000000000100) begin
            n_bad++;
            $display("FAIL reset: got state=%0d err=%b strobes=%b expected 0/0/10000000000100", st, e, sb);
        end
    endtask

    task automatic test_rtype();
        do_reset();
        run_instr(K_R, OP_ADD, 0, 0, 1'b0, "add");
        run_instr(K_R, 11'b11001011000, 2, 0, 1'b1, "sub");
    endtask

    task automatic test_ldur_wait();
        do_reset();
        run_instr(K_LD, OP_LDUR, 0, 3, 1'b0, "ldur_wait3");
        run_instr(K_ST, OP_STUR, 1, 2, 1'b0, "stur_wait2");
        run_instr(K_LD, OP_LDUR, 14, 14, 1'b0, "ldur_wait14");
    endtask

    task automatic test_cbz();
        do_reset();
        run_instr(K_CBZ, 11'b10110100101, 0, 0, 1'b1, "cbz_taken");
        run_instr(K_CBZ, 11'b10110100101, 0, 0, 1'b0, "cbz_not_taken");
    endtask

    task automatic test_illegal();
        logic [3:0] st; logic [13:0] sb; logic e;
        do_reset();
        drive_cycle(1'b0, OP_ILL, 1'b0, 1'b1, st, sb, e);
        drive_cycle(1'b0, OP_ILL, 1'b0, 1'b0, st, sb, e);
        n_cmp++;
        if (st !== 4'd1) begin
            n_bad++;
            $display("FAIL illegal decode: got state %0d expected 1", st);
        end
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, OP_ILL, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), st, sb, e);
            n_cmp++;
            if (st !== 4'd15 || e !== 1'b1 || sb !== 14'd0) begin
                n_bad++;
                $display("FAIL illegal hold[%0d]: got state=%0d err=%b strobes=%b expected 15/1/0", i, st, e, sb);
            end
        end
        drive_cycle(1'b1, OP_ILL, 1'b0, 1'b0, st, sb, e);
        drive_cycle(1'b0, OP_ADD, 1'b0, 1'b0, st, sb, e);
        n_cmp++;
        if (st !== 4'd0 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal recover: got state=%0d err=%b expected 0/0", st, e);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] st; logic [13:0] sb; logic e;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            drive_cycle(1'b0, OP_ADD, 1'b0, 1'b0, st, sb, e);
            n_cmp++;
            if (st !== 4'd0 || e !== 1'b0) begin
                n_bad++;
                $display("FAIL fetch timeout wait %0d: got state=%0d err=%b expected 0/0", i, st, e);
            end
        end
        drive_cycle(1'b0, OP_ADD, 1'b0, 1'b1, st, sb, e);
        n_cmp++;
        if (st !== 4'd15 || e !== 1'b1 || sb !== 14'd0) begin
            n_bad++;
            $display("FAIL fetch timeout: got state=%0d err=%b strobes=%b expected 15/1/0", st, e, sb);
        end
        do_reset();
        run_instr(K_R, OP_ADD, 14, 0, 1'b0, "fetch_ready_late");
        // store that never completes
        drive_cycle(1'b0, OP_STUR, 1'b0, 1'b1, st, sb, e);
        drive_cycle(1'b0, OP_STUR, 1'b0, 1'b0, st, sb, e);
        drive_cycle(1'b0, OP_STUR, 1'b0, 1'b0, st, sb, e);
        for (int i = 1; i <= 16; i++) begin
            drive_cycle(1'b0, OP_STUR, 1'b0, 1'b0, st, sb, e);
            n_cmp++;
            if (st !== 4'd7) begin
                n_bad++;
                $display("FAIL memwr timeout wait %0d: got state %0d expected 7", i, st);
            end
        end
        drive_cycle(1'b0, OP_STUR, 1'b0, 1'b0, st, sb, e);
        n_cmp++;
        if (st !== 4'd15 || e !== 1'b1) begin
            n_bad++;
            $display("FAIL memwr timeout: got state=%0d err=%b expected 15/1", st, e);
        end
    endtask

    task automatic test_midop_reset();
        logic [3:0] st; logic [13:0] sb; logic e;
        do_reset();
        drive_cycle(1'b0, OP_ADD, 1'b0, 1'b1, st, sb, e);
        drive_cycle(1'b0, OP_ADD, 1'b0, 1'b1, st, sb, e);
        drive_cycle(1'b1, OP_ADD, 1'b0, 1'b1, st, sb, e);
        n_cmp++;
        if (st !== 4'd2) begin
            n_bad++;
            $display("FAIL midop exec: got state %0d expected 2", st);
        end
        drive_cycle(1'b0, OP_ADD, 1'b0, 1'b0, st, sb, e);
        n_cmp++;
        if (st !== 4'd0 || sb !== ref_strobes(0, OP_ADD, 1'b0, 1'b0) || e !== 1'b0) begin
            n_bad++;
            $display("FAIL midop reset: got state=%0d strobes=%b err=%b expected 0/%b/0",
                     st, sb, e, ref_strobes(0, OP_ADD, 1'b0, 1'b0));
        end
    endtask

`ifdef LEGV8_PERF_CNT_EN
    task automatic test_perf();
        logic [3:0] st; logic [13:0] sb; logic e;
        do_reset();
        for (int i = 0; i < 5; i++)
            run_instr(K_B, rand_op(K_B), 0, 0, 1'($urandom_range(0, 1)), "perf_b");
        drive_cycle(1'b0, OP_ADD, 1'b0, 1'b0, st, sb, e);
        n_cmp++;
        if (obs_cyc !== 4'd15 || obs_ins !== 4'd5) begin
            n_bad++;
            $display("FAIL perf counts: got cycle=%0d instr=%0d expected 15/5", obs_cyc, obs_ins);
        end
        drive_cycle(1'b0, OP_ADD, 1'b0, 1'b0, st, sb, e);
        n_cmp++;
        if (obs_cyc !== 4'd0 || obs_ins !== 4'd5) begin
            n_bad++;
            $display("FAIL perf wrap: got cycle=%0d instr=%0d expected 0/5", obs_cyc, obs_ins);
        end
    endtask
`endif

    task automatic test_random();
        int kind;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 4);
            run_instr(kind, rand_op(kind), $urandom_range(0, 3), $urandom_range(0, 4),
                      1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_ldur_wait();
        test_cbz();
        test_illegal();
        test_timeout();
        test_midop_reset();
`ifdef LEGV8_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/legv8_multicycle_control.md
Name: legv8_multicycle_control

Overview:
- Moore-style multi-cycle sequencer for the LEGv8 core; replaces the single-cycle main decoder.
- Steps each instruction through fetch/decode/execute/memory/writeback over several cycles, sharing the one ALU and one unified memory port.
- Drives the 2-bit ALUOp consumed by ALU control (00 add, 01 pass-B/CBZ test, 10 R-type funct) plus all datapath mux/enable strobes.
- Handles a ready handshake with memory and flags illegal opcodes and memory timeouts.

Parameters:
- MEM_WAIT_MAX, 15, maximum cycles spent waiting for mem_ready in any memory state before an error (1..255).
- CNT_W, 32, width of the performance counters (Optional Feature only).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  11  instruction[31:21] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load the instruction register
- pc_write  out  1  unconditional PC load
- pc_source  out  1  0 = ALU result (PC+4), 1 = branch-target adder
- reg2loc  out  1  register-file read-port-2 select: 0 = Rm, 1 = Rt
- reg_write  out  1  register-file write enable
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate
- alu_op  out  2  to ALU control
- state  out  4  current state encoding (debug)
- err  out  1  sticky error flag

Behaviour:
- States and encodings:
  - FETCH=0, DECODE=1, EXEC_R=2, R_WB=3, ADDR=4, MEM_RD=5, LD_WB=6, MEM_WR=7, CBZ=8, B=9, ERROR=15.
  - Other encodings are unreachable; if ever entered, go to ERROR.
- Reset:
  - state=FETCH, wait counter=0, err=0.
  - Every strobe is 0, except the FETCH defaults listed below.
  - Reset mid-operation abandons the instruction; no write strobe is asserted in the cycle following a reset.
- Default outputs: all 0 unless listed for the state.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - If mem_ready=1: ir_write=1, pc_write=1, pc_source=0, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: reg2loc = 1 for STUR and CBZ, else 0. Next state by opcode:
  - 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR -> EXEC_R.
  - 11111000010 LDUR, 11111000000 STUR -> ADDR.
  - 10110100xxx CBZ -> CBZ.
  - 000101xxxxx B -> B.
  - Anything else -> ERROR.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; next R_WB.
- R_WB: reg_write=1, mem_to_reg=0; next FETCH.
- ADDR:
  - alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next MEM_RD for LDUR, MEM_WR for STUR (opcode bit 1 decides).
- MEM_RD: mem_read=1, i_or_d=1; on mem_ready go to LD_WB, else stay.
- LD_WB: reg_write=1, mem_to_reg=1; next FETCH.
- MEM_WR: mem_write=1, i_or_d=1, reg2loc=1; on mem_ready go to FETCH, else stay.
- CBZ:
  - alu_src_a=1, alu_src_b=00, reg2loc=1, alu_op=01.
  - If zero=1: pc_write=1, pc_source=1.
  - Next FETCH.
- B: pc_write=1, pc_source=1; next FETCH.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD and MEM_WR, and whenever mem_ready=1.
  - Increments each cycle the state waits with mem_ready=0.
  - When it would exceed MEM_WAIT_MAX, go to ERROR that cycle.
  - mem_ready arriving on the MEM_WAIT_MAX-th wait cycle still completes normally.
- ERROR:
  - All strobes 0; err=1.
  - Absorbing state; only rst leaves it.
- mem_read and mem_write are never both 1.
- pc_write and reg_write are never both 1 in the same cycle.
- Instruction latencies (with mem_ready=1 on first request):
  - R-type 4 cycles, LDUR 5, STUR 4, CBZ 3, B 3.

Optional Feature:
- Macro: LEGV8_PERF_CNT_EN.
- When defined, adds two outputs:
  - cycle_cnt [CNT_W-1:0]: increments every cycle outside reset and ERROR.
  - instr_cnt [CNT_W-1:0]: increments on the final cycle of each completed instruction (R_WB, LD_WB, MEM_WR with mem_ready, CBZ, B).
- Both counters clear on rst and wrap modulo 2^CNT_W.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- rst=1 for 2 cycles, then ADD opcode 10001011000 with mem_ready=1 -> state 0,1,2,3,0; alu_op=10 in EXEC_R; reg_write=1 only in R_WB; err=0.
- LDUR 11111000010, mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_read=1, i_or_d=1; LD_WB asserts reg_write=1, mem_to_reg=1.
- CBZ 10110100101 with zero=1, then again with zero=0 -> pc_write=1, pc_source=1 in CBZ state only in the first case; alu_op=01 in both.
- Opcode 11111111111 in DECODE -> ERROR (state=15), err=1, all strobes 0 for 10 further cycles; rst returns to FETCH with err=0.
- MEM_WAIT_MAX=15, mem_ready held 0 in FETCH -> ERROR on wait cycle 16. Separately, mem_ready on wait cycle 15 -> normal DECODE.
- With LEGV8_PERF_CNT_EN and CNT_W=4: run 5 B instructions (15 cycles) -> instr_cnt=5, cycle_cnt=15; continue 1 cycle -> cycle_cnt wraps to 0.
